d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 49 ++++
 tb/tb_d_flip_flop.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// -----------------------------------------------------------------------------
// d_flip_flop
//
// Positive-edge-triggered D-type storage element with an asynchronous,
// active-low clear. This is the basic state-holding primitive of the datapath;
// register file, PC and pipeline latches are built from it. WIDTH replicates
// the cell into a multi-bit register in which every bit updates and clears
// together. There is no enable and no per-bit control.
//
// Parameters:
//   WIDTH        number of stored bits (default 1)
//   RESET_VALUE  value Q takes while clr is asserted (default all zeros)
//
// Ports:
//   clk  in   1      clock; D is sampled on the rising edge
//   clr  in   1      asynchronous clear, active-low (0 = clear asserted)
//   D    in   WIDTH  data to capture
//   Q    out  WIDTH  registered state
//
// Power-up: Q is left unspecified until the first rising edge or the first
// clr assertion. No initial value is given.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module d_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // NOTE: clr sits in the sensitivity list and is tested first. That makes
  // the clear asynchronous. Q drops to RESET_VALUE on the falling edge of clr
  // without waiting for clk, and clk edges are ignored while clr is low.
  // Releasing clr changes nothing until the next rising clk edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      Q <= RESET_VALUE;
    end else begin
      // NOTE: sequential state is always assigned with <=. Chained
      // registers built from this cell then all sample the pre-edge value.
      Q <= D;
    end
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// -----------------------------------------------------------------------------
// tb_d_flip_flop
//
// Self-checking bench for d_flip_flop. It runs two instances:
//   u_dut1 : default WIDTH=1, RESET_VALUE=0
//   u_dut8 : WIDTH=8, RESET_VALUE=8'hA5
//
// The clock has a 1 ns period. clk starts at 0, so rising edges fall at
// 0.5, 1.5, 2.5 ns and so on. Inputs always change at least 0.1 ns away from
// a rising edge. Outputs are sampled between edges.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_d_flip_flop;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk;
  logic       clr1;
  logic       d1;
  logic       q1;
  logic       clr8;
  logic [7:0] d8;
  logic [7:0] q8;

  int total = 0;
  int bad   = 0;

  d_flip_flop u_dut1 (
    .clk (clk),
    .clr (clr1),
    .D   (d1),
    .Q   (q1)
  );

  d_flip_flop #(
    .WIDTH       (8),
    .RESET_VALUE (RV8)
  ) u_dut8 (
    .clk (clk),
    .clr (clr8),
    .D   (d8),
    .Q   (q8)
  );

  initial begin
    clk = 1'b0;
    forever #0.5 clk = ~clk;
  end

  // Absolute-time wait, in ns.
  task automatic at(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0.2fns: got %h expected %h", name, $realtime, act, exp);
    end
  endtask

  // One record per clock cycle. Inputs are applied at the start of the cycle
  // (integer ns). exp_mid is sampled before the edge, exp_edge just after it.
  typedef struct {
    logic clr;
    logic d;
    bit   chk_mid;
    logic exp_mid;
    logic exp_edge;
  } vec_t;

  vec_t vecs[4];

  // Behavioural reference state for the random phase.
  logic       m1;
  logic [7:0] m8;
  logic       rc1;
  logic       rd1;
  logic       rc8;
  logic [7:0] rd8;

  initial begin
    // Capture sequence: D = 0,1,0,1 -> Q = 0,1,0,1 after each edge.
    vecs[0] = '{clr: 1'b1, d: 1'b0, chk_mid: 1'b0, exp_mid: 1'b0, exp_edge: 1'b0};
    vecs[1] = '{clr: 1'b1, d: 1'b1, chk_mid: 1'b1, exp_mid: 1'b0, exp_edge: 1'b1};
    vecs[2] = '{clr: 1'b1, d: 1'b0, chk_mid: 1'b1, exp_mid: 1'b1, exp_edge: 1'b0};
    vecs[3] = '{clr: 1'b1, d: 1'b1, chk_mid: 1'b1, exp_mid: 1'b0, exp_edge: 1'b1};

    clr1 = 1'b1;
    d1   = 1'b0;
    clr8 = 1'b1;
    d8   = 8'h00;

    // ---- table-driven capture on the 1-bit instance ----
    for (int k = 0; k < 4; k++) begin
      at(realtime'(k));
      clr1 = vecs[k].clr;
      d1   = vecs[k].d;
      at(realtime'(k) + 0.3);
      if (vecs[k].chk_mid) check($sformatf("cap_mid%0d", k), {7'b0, q1}, {7'b0, vecs[k].exp_mid});
      at(realtime'(k) + 0.6);
      check($sformatf("cap_edge%0d", k), {7'b0, q1}, {7'b0, vecs[k].exp_edge});
    end

    // ---- async clear between edges discards the captured 1 ----
    at(4.35); check("pre_clear", {7'b0, q1}, 8'h01);
    at(4.4);  clr1 = 1'b0; d1 = 1'b0;
    at(4.41); check("async_clear", {7'b0, q1}, 8'h00);

    // ---- clear dominates rising edges, D toggled to 1 ----
    at(4.6);  check("clr_dom_4p5", {7'b0, q1}, 8'h00);
    at(5.0);  d1 = 1'b1;
    at(5.6);  check("clr_dom_5p5", {7'b0, q1}, 8'h00);
    at(6.3);  check("clr_hold", {7'b0, q1}, 8'h00);

    // ---- release leaves Q alone until the next rising edge ----
    at(6.4);  clr1 = 1'b1; d1 = 1'b1;
    at(6.45); check("release_no_change", {7'b0, q1}, 8'h00);
    at(6.6);  check("release_load", {7'b0, q1}, 8'h01);
    at(7.6);  check("hold_1", {7'b0, q1}, 8'h01);

    // ---- hold and update, mid-cycle D toggles ignored ----
    at(8.4);  d1 = 1'b0;
    at(8.45); check("pre_update", {7'b0, q1}, 8'h01);
    at(8.6);  check("update_0", {7'b0, q1}, 8'h00);
    at(8.7);  d1 = 1'b1;
    at(8.9);  d1 = 1'b0;
    at(9.1);  d1 = 1'b1;           // falling edge at 9.0 must not load
    at(9.3);  check("mid_toggle", {7'b0, q1}, 8'h00);
    at(9.6);  check("after_toggle", {7'b0, q1}, 8'h01);

    // ---- 8-bit instance: clear value, release, load ----
    at(11.1); check("w8_pre_clear", q8, 8'h00);
    at(11.2); clr8 = 1'b0; d8 = 8'h3C;
    at(11.25); check("w8_clear", q8, RV8);
    at(11.6); check("w8_clr_dom", q8, RV8);
    at(12.2); clr8 = 1'b1;
    at(12.3); check("w8_release_no_change", q8, RV8);
    at(12.6); check("w8_load", q8, 8'h3C);

    // ---- randomized phase against the reference model ----
    // Model: a low clr forces the reset value at once. Otherwise Q becomes
    // whatever D is at the rising edge.
    m1 = 1'b0;
    m8 = 8'h00;
    for (int n = 0; n < 200; n++) begin
      realtime base;
      base = 13.0 + realtime'(n);
      rc1 = (n == 0) ? 1'b0 : ($urandom_range(4) != 0);
      rc8 = (n == 0) ? 1'b0 : ($urandom_range(4) != 0);
      rd1 = 1'($urandom);
      rd8 = 8'($urandom);
      at(base + 0.1);
      clr1 = rc1;
      clr8 = rc8;
      d1   = ~rd1;                 // glitch value, overwritten before the edge
      d8   = ~rd8;
      if (!rc1) m1 = 1'b0;
      if (!rc8) m8 = RV8;
      at(base + 0.2);
      check($sformatf("rnd_mid1_%0d", n), {7'b0, q1}, {7'b0, m1});
      check($sformatf("rnd_mid8_%0d", n), q8, m8);
      at(base + 0.3);
      d1 = rd1;
      d8 = rd8;
      at(base + 0.6);
      if (rc1) m1 = rd1;
      if (rc8) m8 = rd8;
      check($sformatf("rnd_edge1_%0d", n), {7'b0, q1}, {7'b0, m1});
      check($sformatf("rnd_edge8_%0d", n), q8, m8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
